branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter INDEX_BITS, default 4: table index width; the table holds 2^INDEX_BITS entries of 2-bit counters.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_if_pc  input  32  PC of the instruction in IF.
REQ-005 i_if_is_branch  input  1  IF instruction is BEQ/BNE (pre-decoded).
REQ-006 o_prediction  output  1  predicted direction for i_if_pc; travels down the pipe as the EX-stage prediction.
REQ-007 i_ex_branch  input  1  EX holds a resolved BEQ/BNE.
REQ-008 i_ex_taken  input  1  actual outcome from EX.
REQ-009 i_ex_prediction  input  1  prediction originally issued for that branch.
REQ-010 i_ex_pc  input  32  PC of the branch in EX.
REQ-011 i_ex_target  input  32  branch target address.
REQ-012 o_redirect_valid  output  1  one-cycle pulse requesting an IF/ID/EX flush and PC reload.
REQ-013 o_redirect_pc  output  32  corrected fetch PC; valid while o_redirect_valid=1.
REQ-014 o_branch_count, o_mispredict_count  output  32 each  statistics; present only with BRANCH_PRED_STATS_EN.

Function
REQ-015 Index = pc[INDEX_BITS+1:2] for both lookup and update; no tags, so aliasing is permitted.
REQ-016 Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; prediction = counter bit 1.
REQ-017 o_prediction is combinational: table[idx(i_if_pc)][1] when i_if_is_branch=1, else 0.
REQ-018 Update occurs when i_ex_branch=1: taken increments, not-taken decrements, saturating at 11 and 00; the table is written at the clock edge.
REQ-019 A lookup and an update to the same index in the same cycle: o_prediction reflects the pre-update value; the new value is visible from the next cycle.
REQ-020 Mispredict = i_ex_branch && (i_ex_taken != i_ex_prediction).
REQ-021 On mispredict, the next cycle has o_redirect_valid=1 and o_redirect_pc = i_ex_taken ? i_ex_target : i_ex_pc+4, with 32-bit wrap-around.
REQ-022 Redirect latency is exactly 1 cycle; pulse width is exactly 1 cycle.
REQ-023 Mispredicts on consecutive cycles each produce their own pulse, carrying the corresponding PC.
REQ-024 When i_ex_branch=0, i_ex_taken, i_ex_prediction, i_ex_pc and i_ex_target are ignored.
REQ-025 o_redirect_pc holds its last value when o_redirect_valid=0.

Reset
REQ-026 While reset=1 at an edge: every table entry becomes 01, o_redirect_valid=0, o_redirect_pc=0, and the statistics counters become 0.
REQ-027 Reset overrides any simultaneous update or mispredict; no redirect pulse follows a reset cycle.
REQ-028 After reset, o_prediction=0 for every PC.

Configuration
REQ-029 Macro BRANCH_PRED_STATS_EN: when defined, o_branch_count increments on each i_ex_branch=1 cycle and o_mispredict_count increments on each mispredict; both saturate at 0xFFFFFFFF.
REQ-030 When BRANCH_PRED_STATS_EN is undefined, the counter ports and logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset, then i_if_pc=0x40 with i_if_is_branch=1 -> o_prediction=0.
REQ-032 Two updates, taken, at pc=0x40 with prediction=0 -> first cycle after each: redirect pulse, o_redirect_pc = i_ex_target (0x100); afterwards o_prediction=1 for pc 0x40 and for alias pc 0x80 (INDEX_BITS=4).
REQ-033 Counter at 11, then not-taken with prediction=1, pc=0x44 -> redirect pulse with o_redirect_pc=0x48; counter=10, prediction stays 1.
REQ-034 Same-cycle lookup and update at index 3 -> o_prediction shows the old value that cycle and the new value the next cycle.
REQ-035 Mispredicts on cycles N and N+1 (pc 0x10 taken to 0x200; pc 0x14 not-taken) -> pulses on N+1 (0x200) and N+2 (0x18); reset asserted on cycle N -> no pulse at all.
REQ-036 With BRANCH_PRED_STATS_EN defined: 5 branches including 2 mispredicts -> o_branch_count=5, o_mispredict_count=2.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolution signals of the branch predictor.
// Statistics ports exist only when BRANCH_PRED_STATS_EN is defined.
interface branch_predictor_if;
  logic [31:0] i_if_pc;
  logic        i_if_is_branch;
  logic        o_prediction;
  logic        i_ex_branch;
  logic        i_ex_taken;
  logic        i_ex_prediction;
  logic [31:0] i_ex_pc;
  logic [31:0] i_ex_target;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] o_branch_count;
  logic [31:0] o_mispredict_count;
`endif

  modport master (
    output i_if_pc, i_if_is_branch, i_ex_branch, i_ex_taken,
           i_ex_prediction, i_ex_pc, i_ex_target,
`ifdef BRANCH_PRED_STATS_EN
    input  o_branch_count, o_mispredict_count,
`endif
    input  o_prediction, o_redirect_valid, o_redirect_pc
  );

  modport slave (
    input  i_if_pc, i_if_is_branch, i_ex_branch, i_ex_taken,
           i_ex_prediction, i_ex_pc, i_ex_target,
`ifdef BRANCH_PRED_STATS_EN
    output o_branch_count, o_mispredict_count,
`endif
    output o_prediction, o_redirect_valid, o_redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Untagged 2-bit saturating-counter direction predictor with one-cycle mispredict redirect.
// Optional statistics counters are built when BRANCH_PRED_STATS_EN is defined.
module branch_predictor #(
  parameter int INDEX_BITS = 4
) (
  input logic               clk,
  input logic               reset,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]            ctr_table [ENTRIES];
  logic [INDEX_BITS-1:0] if_idx;
  logic [INDEX_BITS-1:0] ex_idx;
  logic                  mispredict;
  logic [31:0]           fix_pc;
  logic                  redirect_vld_p1;
  logic [31:0]           redirect_pc_p1;

  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    else       return (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
  endfunction

  assign if_idx = bp.i_if_pc[INDEX_BITS+1:2];
  assign ex_idx = bp.i_ex_pc[INDEX_BITS+1:2];

  // Table read is asynchronous, so a same-cycle update is seen only after the edge.
  assign bp.o_prediction = bp.i_if_is_branch & ctr_table[if_idx][1];

  assign mispredict = bp.i_ex_branch & (bp.i_ex_taken ^ bp.i_ex_prediction);
  assign fix_pc     = bp.i_ex_taken ? bp.i_ex_target : bp.i_ex_pc + 32'd4;

  // ---- stage p1: table update and registered redirect ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_table[i] <= 2'b01;
      redirect_vld_p1 <= 1'b0;
      redirect_pc_p1  <= 32'd0;
    end else begin
      if (bp.i_ex_branch) ctr_table[ex_idx] <= ctr_next(ctr_table[ex_idx], bp.i_ex_taken);
      redirect_vld_p1 <= mispredict;
      if (mispredict) redirect_pc_p1 <= fix_pc;
    end
  end

  assign bp.o_redirect_valid = redirect_vld_p1;
  assign bp.o_redirect_pc    = redirect_pc_p1;

`ifdef BRANCH_PRED_STATS_EN
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else begin
      if (bp.i_ex_branch) branch_cnt  <= sat_inc32(branch_cnt);
      if (mispredict)     mispred_cnt <= sat_inc32(mispred_cnt);
    end
  end

  assign bp.o_branch_count     = branch_cnt;
  assign bp.o_mispredict_count = mispred_cnt;
`endif

  // Only the index bits of each PC take part in the lookup.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.i_if_pc[31:INDEX_BITS+2], bp.i_if_pc[1:0],
                            bp.i_ex_pc[31:INDEX_BITS+2]};
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios plus randomized traffic against a
// table-of-integers reference model; also covers statistics when BRANCH_PRED_STATS_EN is set.
module tb_branch_predictor;
  localparam int INDEX_BITS = 4;
  localparam int N = 1 << INDEX_BITS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if bp ();
  branch_predictor #(.INDEX_BITS(INDEX_BITS)) dut (.clk(clk), .reset(reset), .bp(bp));

  int          total = 0;
  int          bad = 0;
  int          mdl_ctr [N];   // strength 0..3, taken predicted when >= 2
  bit          exp_vld;
  logic [31:0] exp_pc;
  longint      exp_br;
  longint      exp_mis;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc >> 2) % N;
  endfunction

  function automatic logic exp_pred();
    if (!bp.i_if_is_branch) return 1'b0;
    return mdl_ctr[idx_of(bp.i_if_pc)] >= 2;
  endfunction

  // Apply what the DUT saw at the edge just passed to the model.
  task automatic model_edge();
    if (reset) begin
      for (int i = 0; i < N; i++) mdl_ctr[i] = 1;
      exp_vld = 0;
      exp_pc  = 32'd0;
      exp_br  = 0;
      exp_mis = 0;
    end else begin
      exp_vld = 0;
      if (bp.i_ex_branch) begin
        int k;
        k = idx_of(bp.i_ex_pc);
        if (bp.i_ex_taken) mdl_ctr[k] = (mdl_ctr[k] == 3) ? 3 : mdl_ctr[k] + 1;
        else               mdl_ctr[k] = (mdl_ctr[k] == 0) ? 0 : mdl_ctr[k] - 1;
        if (exp_br < 64'hFFFF_FFFF) exp_br++;
        if (bp.i_ex_taken != bp.i_ex_prediction) begin
          exp_vld = 1;
          exp_pc  = bp.i_ex_taken ? bp.i_ex_target : 32'(bp.i_ex_pc + 32'd4);
          if (exp_mis < 64'hFFFF_FFFF) exp_mis++;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check("pred", {31'd0, bp.o_prediction}, {31'd0, exp_pred()});
    check("rvld", {31'd0, bp.o_redirect_valid}, {31'd0, exp_vld});
    check("rpc", bp.o_redirect_pc, exp_pc);
`ifdef BRANCH_PRED_STATS_EN
    check("brcnt", bp.o_branch_count, exp_br[31:0]);
    check("miscnt", bp.o_mispredict_count, exp_mis[31:0]);
`endif
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic fe(input logic [31:0] pc, input logic isb);
    bp.i_if_pc        = pc;
    bp.i_if_is_branch = isb;
  endtask

  task automatic ex(input logic br, input logic tk, input logic pr,
                    input logic [31:0] pc, input logic [31:0] tg);
    bp.i_ex_branch     = br;
    bp.i_ex_taken      = tk;
    bp.i_ex_prediction = pr;
    bp.i_ex_pc         = pc;
    bp.i_ex_target     = tg;
  endtask

  // No branch in EX; the other EX fields carry junk that must be ignored.
  task automatic ex_idle();
    ex(1'b0, 1'($urandom), 1'($urandom), $urandom, $urandom);
  endtask

  initial begin
    reset = 1'b1;
    fe(32'h0, 1'b0);
    ex(1'b1, 1'b1, 1'b0, 32'h40, 32'h100);
    @(posedge clk); #1; model_edge();
    @(posedge clk); #1; model_edge();
    reset = 1'b0;
    ex_idle();

    // Fresh table predicts not-taken everywhere.
    for (int i = 0; i < N; i++) begin
      fe(32'(i * 4), 1'b1);
      #1 check("rst_pred", {31'd0, bp.o_prediction}, 32'd0);
    end
    check("rst_rvld", {31'd0, bp.o_redirect_valid}, 32'd0);
    check("rst_rpc", bp.o_redirect_pc, 32'd0);
    fe(32'h40, 1'b1);
    #1 check("pred_40_init", {31'd0, bp.o_prediction}, 32'd0);
    cycle();

    // Two taken mispredicts at 0x40 train the entry and its alias 0x80.
    ex(1'b1, 1'b1, 1'b0, 32'h40, 32'h100);
    cycle();
    #1 check("train1_vld", {31'd0, bp.o_redirect_valid}, 32'd1);
    check("train1_pc", bp.o_redirect_pc, 32'h100);
    cycle();
    #1 check("train2_vld", {31'd0, bp.o_redirect_valid}, 32'd1);
    check("train2_pc", bp.o_redirect_pc, 32'h100);
    ex_idle();
    #1 check("pulse_width", {31'd0, bp.o_redirect_valid}, 32'd1);
    cycle();
    #1 check("pulse_end", {31'd0, bp.o_redirect_valid}, 32'd0);
    check("pc_hold", bp.o_redirect_pc, 32'h100);
    fe(32'h40, 1'b1);
    #1 check("pred_40", {31'd0, bp.o_prediction}, 32'd1);
    fe(32'h80, 1'b1);
    #1 check("pred_alias80", {31'd0, bp.o_prediction}, 32'd1);
    fe(32'h80, 1'b0);
    #1 check("pred_nonbranch", {31'd0, bp.o_prediction}, 32'd0);
    cycle();

    // Saturate 0x44 to strong-T, then one not-taken drops it to weak-T only.
    ex(1'b1, 1'b1, 1'b1, 32'h44, 32'h300);
    cycle(); cycle(); cycle();
    ex(1'b1, 1'b0, 1'b1, 32'h44, 32'h300);
    cycle();
    #1 check("nt_vld", {31'd0, bp.o_redirect_valid}, 32'd1);
    check("nt_pc", bp.o_redirect_pc, 32'h48);
    ex_idle();
    fe(32'h44, 1'b1);
    #1 check("pred_44_weak", {31'd0, bp.o_prediction}, 32'd1);
    cycle();

    // Same-cycle lookup and update at index 3.
    fe(32'h0C, 1'b1);
    ex(1'b1, 1'b1, 1'b1, 32'h4C, 32'h500);
    #1 check("same_old", {31'd0, bp.o_prediction}, 32'd0);
    cycle();
    ex_idle();
    #1 check("same_new", {31'd0, bp.o_prediction}, 32'd1);
    cycle();

    // Back-to-back mispredicts each get their own pulse.
    ex(1'b1, 1'b1, 1'b0, 32'h10, 32'h200);
    cycle();
    #1 check("b2b1_vld", {31'd0, bp.o_redirect_valid}, 32'd1);
    check("b2b1_pc", bp.o_redirect_pc, 32'h200);
    ex(1'b1, 1'b0, 1'b1, 32'h14, 32'h999);
    cycle();
    #1 check("b2b2_vld", {31'd0, bp.o_redirect_valid}, 32'd1);
    check("b2b2_pc", bp.o_redirect_pc, 32'h18);
    ex_idle();
    cycle();

    // Reset wins over a simultaneous mispredict.
    reset = 1'b1;
    ex(1'b1, 1'b1, 1'b0, 32'h10, 32'h200);
    cycle();
    reset = 1'b0;
    ex_idle();
    #1 check("rst_mis_vld", {31'd0, bp.o_redirect_valid}, 32'd0);
    check("rst_mis_pc", bp.o_redirect_pc, 32'd0);
    fe(32'h10, 1'b1);
    #1 check("rst_mis_pred", {31'd0, bp.o_prediction}, 32'd0);
    cycle();
    #1 check("rst_mis_vld2", {31'd0, bp.o_redirect_valid}, 32'd0);

    // Fall-through address wraps at 32 bits.
    ex(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234);
    cycle();
    #1 check("wrap_vld", {31'd0, bp.o_redirect_valid}, 32'd1);
    check("wrap_pc", bp.o_redirect_pc, 32'h0);
    ex_idle();
    cycle();

`ifdef BRANCH_PRED_STATS_EN
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ex(1'b1, 1'b0, 1'b0, 32'h100, 32'h0);  cycle();
    ex(1'b1, 1'b1, 1'b0, 32'h104, 32'h80); cycle();
    ex_idle();                              cycle();
    ex(1'b1, 1'b0, 1'b0, 32'h108, 32'h0);  cycle();
    ex(1'b1, 1'b0, 1'b1, 32'h10C, 32'h0);  cycle();
    ex(1'b1, 1'b1, 1'b1, 32'h110, 32'h40); cycle();
    ex_idle();
    #1 check("stats_br", bp.o_branch_count, 32'd5);
    check("stats_mis", bp.o_mispredict_count, 32'd2);
    cycle();
`endif

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 39) == 0);
      fe($urandom, 1'($urandom));
      ex($urandom_range(0, 9) < 6, 1'($urandom), 1'($urandom),
         ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : $urandom, $urandom);
      cycle();
    end
    reset = 1'b0;
    ex_idle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
